// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer
// Captures two operands (A then B) from a shared switch bus on successive
// rising edges of a load strobe, holds them for the downstream ALU stage,
// and registers the ALU result one cycle after B is captured.
module alu_operand_sequencer #(
    parameter int WIDTH     = 6,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     data_in,
    input  logic                 load_en,
    input  logic                 clear,
    input  logic [WIDTH-1:0]     alu_result,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [WIDTH-1:0]     result,
    output logic                 result_valid,
    output logic [CNT_WIDTH-1:0] ops_done,
    output logic [1:0]           state
);

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        EVAL   = 2'b10,
        HOLD   = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic                 r_load_q;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [WIDTH-1:0]     r_result;
    logic                 r_valid;
    logic [CNT_WIDTH-1:0] r_ops_done;

    state_t               w_state_nxt;
    logic                 w_ld;
    logic [WIDTH-1:0]     w_a_nxt;
    logic [WIDTH-1:0]     w_b_nxt;
    logic [WIDTH-1:0]     w_result_nxt;
    logic                 w_valid_nxt;
    logic [CNT_WIDTH-1:0] w_ops_done_nxt;

    // A load acts only on the rising edge of the strobe level.
    assign w_ld = load_en & ~r_load_q;

    // Strobe history; resets high so a button held through reset release is ignored.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            r_load_q <= 1'b1;
        end else begin
            r_load_q <= load_en;
        end
    end

    // Next-state and next-datapath decode; clear overrides every state action.
    always_comb begin
        // NOTE: every combinational output gets a hold/default value first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        w_state_nxt    = r_state;
        w_a_nxt        = r_a;
        w_b_nxt        = r_b;
        w_result_nxt   = r_result;
        w_valid_nxt    = r_valid;
        w_ops_done_nxt = r_ops_done;

        if (clear) begin
            w_state_nxt    = WAIT_A;
            w_a_nxt        = '0;
            w_b_nxt        = '0;
            w_result_nxt   = '0;
            w_valid_nxt    = 1'b0;
            w_ops_done_nxt = '0;
        end else begin
            unique case (r_state)
                WAIT_A: begin
                    if (w_ld) begin
                        w_a_nxt     = data_in;
                        w_state_nxt = WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (w_ld) begin
                        w_b_nxt     = data_in;
                        w_state_nxt = EVAL;
                    end
                end
                EVAL: begin
                    // The ALU has had a full cycle to settle on the new A/B.
                    w_result_nxt   = alu_result;
                    w_valid_nxt    = 1'b1;
                    w_ops_done_nxt = r_ops_done + CNT_ONE;
                    w_state_nxt    = HOLD;
                end
                HOLD: begin
                    // New A starts the next operation; B keeps its old value and
                    // result is marked stale until the next evaluation.
                    if (w_ld) begin
                        w_a_nxt     = data_in;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = WAIT_B;
                    end
                end
                default: begin
                    w_state_nxt = WAIT_A;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT_A;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand, result and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_result   <= '0;
            r_valid    <= 1'b0;
            r_ops_done <= '0;
        end else begin
            r_a        <= w_a_nxt;
            r_b        <= w_b_nxt;
            r_result   <= w_result_nxt;
            r_valid    <= w_valid_nxt;
            r_ops_done <= w_ops_done_nxt;
        end
    end

    assign A            = r_a;
    assign B            = r_b;
    assign result       = r_result;
    assign result_valid = r_valid;
    assign ops_done     = r_ops_done;
    assign state        = r_state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed steps from the
// operating rules plus a randomized run of complete operations.
module tb_alu_operand_sequencer;

    localparam int WIDTH     = 6;
    localparam int CNT_WIDTH = 8;

    localparam logic [1:0] S_WAIT_A = 2'b00;
    localparam logic [1:0] S_WAIT_B = 2'b01;
    localparam logic [1:0] S_EVAL   = 2'b10;
    localparam logic [1:0] S_HOLD   = 2'b11;

    logic                 clk;
    logic                 rst;
    logic [WIDTH-1:0]     data_in;
    logic                 load_en;
    logic                 clear;
    logic [WIDTH-1:0]     alu_result;
    logic [WIDTH-1:0]     A;
    logic [WIDTH-1:0]     B;
    logic [WIDTH-1:0]     result;
    logic                 result_valid;
    logic [CNT_WIDTH-1:0] ops_done;
    logic [1:0]           state;

    int n_tests = 0;
    int n_fail  = 0;

    // ALU stand-in: signed less-than comparator (mode 0) or wrapping sum (mode 1).
    logic alu_mode;
    assign alu_result = alu_mode ? (A + B)
                                 : (($signed(A) < $signed(B)) ? 6'd1 : 6'd0);

    alu_operand_sequencer #(
        .WIDTH    (WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .load_en     (load_en),
        .clear       (clear),
        .alu_result  (alu_result),
        .A           (A),
        .B           (B),
        .result      (result),
        .result_valid(result_valid),
        .ops_done    (ops_done),
        .state       (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result for a completed operation, from the operand values alone.
    function automatic logic [WIDTH-1:0] ref_alu(input logic mode,
                                                 input logic signed [WIDTH-1:0] a,
                                                 input logic signed [WIDTH-1:0] b);
        int sum;
        if (mode) begin
            sum = (int'(a) + int'(b)) & ((1 << WIDTH) - 1);
            return WIDTH'(sum);
        end
        return (a < b) ? WIDTH'(1) : WIDTH'(0);
    endfunction

    // One press of the load button: high for one cycle, then low.
    task automatic strobe(input logic [WIDTH-1:0] d);
        @(negedge clk);
        data_in = d;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Reset-value check of every output.
    task automatic check_reset_vals(input string pfx);
        check({pfx, "_state"}, 32'(state), 32'(S_WAIT_A));
        check({pfx, "_A"}, 32'(A), 0);
        check({pfx, "_B"}, 32'(B), 0);
        check({pfx, "_result"}, 32'(result), 0);
        check({pfx, "_valid"}, 32'(result_valid), 0);
        check({pfx, "_ops"}, 32'(ops_done), 0);
    endtask

    // Model of the completed-operation count, kept as a plain integer.
    int exp_ops = 0;

    // One full operation: load A, load B, then the result appears one clock later.
    task automatic do_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] old_b;
        logic [WIDTH-1:0] old_res;
        old_b   = B;
        old_res = result;
        strobe(a);
        check({tag, "_A"}, 32'(A), 32'(a));
        check({tag, "_Bkept"}, 32'(B), 32'(old_b));
        check({tag, "_stale"}, 32'(result_valid), 0);
        check({tag, "_stWB"}, 32'(state), 32'(S_WAIT_B));
        strobe(b);
        check({tag, "_B"}, 32'(B), 32'(b));
        check({tag, "_stEV"}, 32'(state), 32'(S_EVAL));
        check({tag, "_noval"}, 32'(result_valid), 0);
        check({tag, "_reshold"}, 32'(result), 32'(old_res));
        @(posedge clk);
        #1;
        exp_ops++;
        check({tag, "_res"}, 32'(result), 32'(ref_alu(alu_mode, a, b)));
        check({tag, "_valid"}, 32'(result_valid), 1);
        check({tag, "_ops"}, 32'(ops_done), 32'(exp_ops % (1 << CNT_WIDTH)));
        check({tag, "_stHD"}, 32'(state), 32'(S_HOLD));
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] held_b;

        alu_mode = 1'b0;
        rst      = 1'b1;
        load_en  = 1'b1;
        clear    = 1'b0;
        data_in  = 6'h15;

        // Reset with the strobe held high, then release with it still high.
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("heldld_state", 32'(state), 32'(S_WAIT_A));
        check("heldld_A", 32'(A), 0);
        @(negedge clk);
        load_en = 1'b0;

        // -2 then 3 with the comparator: A<B gives 1.
        do_op("op1", 6'b111110, 6'b000011);
        check("op1_Ahex", 32'(A), 32'h3E);

        // Restart from HOLD: new A, B kept, then new B = -32; 5 < -32 is false.
        do_op("op2", 6'b000101, 6'b100000);

        // clear on the same edge as a B load.
        strobe(6'h0A);
        @(negedge clk);
        data_in = 6'h07;
        load_en = 1'b1;
        clear   = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals("clr");
        exp_ops = 0;
        @(negedge clk);
        load_en = 1'b0;
        clear   = 1'b0;

        // Randomized full operations through the summing ALU; the 256th wraps the counter.
        alu_mode = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ra = WIDTH'($urandom_range(0, 63));
            rb = WIDTH'($urandom_range(0, 63));
            do_op("rnd", ra, rb);
        end
        check("wrap_ops", 32'(ops_done), 0);

        // Strobe held for 10 cycles: exactly one capture.
        held_b = B;
        @(negedge clk);
        data_in = 6'h2B;
        load_en = 1'b1;
        repeat (10) @(negedge clk);
        check("hold10_state", 32'(state), 32'(S_WAIT_B));
        check("hold10_A", 32'(A), 32'h2B);
        check("hold10_B", 32'(B), 32'(held_b));
        load_en = 1'b0;

        // Asynchronous reset while in EVAL, between clock edges.
        strobe(6'h11);
        check("pre_async_state", 32'(state), 32'(S_EVAL));
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        @(posedge clk);
        #1;
        check_reset_vals("arst_edge");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("post_arst_state", 32'(state), 32'(S_WAIT_A));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
